// File: rtl/datapath_pkg.sv
// Shared command encodings, ULA select codes and converter state type
// for the X/Y/Z datapath stage.
package datapath_pkg;

  localparam logic [1:0] REG_HOLD   = 2'b00;
  localparam logic [1:0] REG_LOAD   = 2'b01;
  localparam logic [1:0] REG_SHIFTR = 2'b10;
  localparam logic [1:0] REG_RESET  = 2'b11;

  localparam logic ULA_ADD = 1'b0;
  localparam logic ULA_SUB = 1'b1;

  typedef enum logic {IDLE, CONV} bcd_state_t;

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/datapath_xyz_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// abort has priority over start; bcd holds its last result while converting.
module bin2bcd_seq
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  bcd_state_t        state, state_nxt;
  logic [WIDTH-1:0]  sh, sh_nxt;
  logic [BW-1:0]     acc, acc_nxt, acc_adj, acc_step;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bcd_nxt;
  logic              valid_nxt;

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = dd_adjust(acc[4*i +: 4]);
    end
    acc_step = {acc_adj[BW-2:0], sh[WIDTH-1]};
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd;
    valid_nxt = valid;
    if (abort) begin
      state_nxt = IDLE;
      bcd_nxt   = '0;
      valid_nxt = 1'b0;
    end else if (start) begin
      // A start while converting simply restarts from the new value.
      state_nxt = CONV;
      sh_nxt    = value;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        CONV: begin
          sh_nxt  = sh << 1;
          acc_nxt = acc_step;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_nxt = IDLE;
            bcd_nxt   = acc_step;
            valid_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      bcd   <= bcd_nxt;
      valid <= valid_nxt;
    end
  end

  assign busy = (state == CONV);

endmodule

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath with add/sub ULA; every Z load launches a
// sequential BCD conversion of the loaded value for the display driver.
module datapath_xyz
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            Tx,
  input  logic [1:0]            Ty,
  input  logic [1:0]            Tz,
  input  logic                  Tula,
  input  logic [WIDTH-1:0]      Entrada,
  output logic [WIDTH-1:0]      X,
  output logic [WIDTH-1:0]      Y,
  output logic [WIDTH-1:0]      Z,
  output logic                  ovf,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  // Bit WIDTH is the carry for add and the borrow (X < Y) for sub.
  logic [WIDTH:0] ula;

  always_comb begin
    if (Tula == ULA_SUB) ula = {1'b0, X} - {1'b0, Y};
    else                 ula = {1'b0, X} + {1'b0, Y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X <= '0;
    end else begin
      case (Tx)
        REG_LOAD:   X <= Entrada;
        REG_SHIFTR: X <= X >> 1;
        REG_RESET:  X <= '0;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y   <= '0;
      ovf <= 1'b0;
    end else begin
      case (Ty)
        REG_LOAD: begin
          Y   <= ula[WIDTH-1:0];
          ovf <= ula[WIDTH];
        end
        REG_SHIFTR: Y <= Y >> 1;
        REG_RESET: begin
          Y   <= '0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Shiftr on Z is reserved and behaves as hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z <= '0;
    end else begin
      case (Tz)
        REG_LOAD:  Z <= Y;
        REG_RESET: Z <= '0;
        default:   ;
      endcase
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (Tz == REG_LOAD),
    .abort (Tz == REG_RESET),
    .value (Y),
    .busy  (busy),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

endmodule

// File: tb/tb_datapath_xyz.sv
// Scoreboard bench for datapath_xyz: a driver pushes model-predicted
// post-edge outputs, a monitor pops and compares them after each edge.
module tb_datapath_xyz;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned MASK   = (1 << WIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          Tx, Ty, Tz;
  logic                Tula;
  logic [WIDTH-1:0]    Entrada;
  logic [WIDTH-1:0]    X, Y, Z;
  logic                ovf, busy, bcd_valid;
  logic [4*DIGITS-1:0] bcd;

  datapath_xyz #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Tx        (Tx),
    .Ty        (Ty),
    .Tz        (Tz),
    .Tula      (Tula),
    .Entrada   (Entrada),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .ovf       (ovf),
    .busy      (busy),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]    x, y, z;
    logic                ovf, busy, valid;
    logic [4*DIGITS-1:0] bcd;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: plain integers plus a countdown for the conversion.
  int unsigned         mx, my, mz, movf, mvalid, left, cval;
  logic [4*DIGITS-1:0] mbcd;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mz = 0; movf = 0; mvalid = 0; left = 0; cval = 0;
    mbcd = '0;
  endtask

  task automatic step(input logic [1:0] tx, input logic [1:0] ty, input logic [1:0] tz,
                      input logic tula, input int unsigned e);
    int unsigned ox, oy, res, carry;
    exp_t        ex;
    @(negedge clk);
    Tx = tx; Ty = ty; Tz = tz; Tula = tula; Entrada = WIDTH'(e);
    ox = mx;
    oy = my;
    if (tula) begin
      res   = (ox - oy) & MASK;
      carry = (ox < oy) ? 1 : 0;
    end else begin
      res   = (ox + oy) & MASK;
      carry = ((ox + oy) > MASK) ? 1 : 0;
    end
    case (tx)
      2'd1: mx = e & MASK;
      2'd2: mx = ox / 2;
      2'd3: mx = 0;
      default: ;
    endcase
    case (ty)
      2'd1: begin my = res; movf = carry; end
      2'd2: my = oy / 2;
      2'd3: begin my = 0; movf = 0; end
      default: ;
    endcase
    if (tz == 2'd1) begin
      mz = oy; cval = oy; left = WIDTH; mvalid = 0;
    end else if (tz == 2'd3) begin
      mz = 0; left = 0; mbcd = '0; mvalid = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        mbcd   = to_bcd(cval);
        mvalid = 1;
      end
    end
    ex.x = WIDTH'(mx); ex.y = WIDTH'(my); ex.z = WIDTH'(mz);
    ex.ovf = movf[0]; ex.busy = (left > 0); ex.valid = mvalid[0]; ex.bcd = mbcd;
    sbq.push_back(ex);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic hold();
    step(2'd0, 2'd0, 2'd0, 1'b0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("sb_X", 32'(X), 32'(mon_e.x));
        chk("sb_Y", 32'(Y), 32'(mon_e.y));
        chk("sb_Z", 32'(Z), 32'(mon_e.z));
        chk("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
        chk("sb_busy", 32'(busy), 32'(mon_e.busy));
        chk("sb_valid", 32'(bcd_valid), 32'(mon_e.valid));
        chk("sb_bcd", 32'(bcd), 32'(mon_e.bcd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned r;
    logic [1:0]  rtz;
    rst = 1'b1; Tx = '0; Ty = '0; Tz = '0; Tula = 1'b0; Entrada = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_X", 32'(X), 0);
    chk("rst_Y", 32'(Y), 0);
    chk("rst_Z", 32'(Z), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(bcd_valid), 0);
    rst = 1'b0;

    // clrld, add twice, div2
    step(2'd1, 2'd3, 2'd3, 1'b0, 25); settle();
    chk("clrld_X", 32'(X), 25);
    chk("clrld_Y", 32'(Y), 0);
    step(2'd0, 2'd1, 2'd0, 1'b0, 0); settle();
    chk("add1_Y", 32'(Y), 25);
    step(2'd0, 2'd1, 2'd0, 1'b0, 0); settle();
    chk("add2_Y", 32'(Y), 50);
    chk("add2_ovf", 32'(ovf), 0);
    step(2'd0, 2'd2, 2'd0, 1'b0, 0); settle();
    chk("div2a_Y", 32'(Y), 25);
    step(2'd0, 2'd2, 2'd0, 1'b0, 0); settle();
    chk("div2b_Y", 32'(Y), 12);
    chk("div2b_X", 32'(X), 25);

    // carry out: 200 + 100
    step(2'd1, 2'd3, 2'd0, 1'b0, 100);
    step(2'd1, 2'd1, 2'd0, 1'b0, 200);
    step(2'd0, 2'd1, 2'd0, 1'b0, 0); settle();
    chk("carry_Y", 32'(Y), 44);
    chk("carry_ovf", 32'(ovf), 1);

    // borrow: 10 - 20
    step(2'd1, 2'd3, 2'd0, 1'b0, 20);
    step(2'd1, 2'd1, 2'd0, 1'b0, 10);
    step(2'd0, 2'd1, 2'd0, 1'b1, 0); settle();
    chk("borrow_Y", 32'(Y), 246);
    chk("borrow_ovf", 32'(ovf), 1);

    // display 200
    step(2'd1, 2'd3, 2'd0, 1'b0, 200);
    step(2'd0, 2'd1, 2'd0, 1'b0, 0);
    step(2'd0, 2'd0, 2'd1, 1'b0, 0); settle();
    chk("disp_Z", 32'(Z), 200);
    chk("disp_busy", 32'(busy), 1);
    repeat (7) hold();
    hold(); settle();
    chk("disp_bcd", 32'(bcd), 32'h200);
    chk("disp_valid", 32'(bcd_valid), 1);
    chk("disp_done", 32'(busy), 0);

    // reload with 99 three cycles into a conversion
    step(2'd1, 2'd3, 2'd1, 1'b0, 99);
    step(2'd0, 2'd1, 2'd0, 1'b0, 0);
    hold();
    step(2'd0, 2'd0, 2'd1, 1'b0, 0); settle();
    chk("reload_oldbcd", 32'(bcd), 32'h200);
    chk("reload_valid", 32'(bcd_valid), 0);
    repeat (7) hold();
    hold(); settle();
    chk("reload_bcd", 32'(bcd), 32'h099);
    chk("reload_done", 32'(bcd_valid), 1);

    // asynchronous reset during a conversion
    step(2'd0, 2'd0, 2'd1, 1'b0, 0);
    repeat (3) hold();
    settle();
    rst = 1'b1;
    #1;
    chk("arst_X", 32'(X), 0);
    chk("arst_Y", 32'(Y), 0);
    chk("arst_Z", 32'(Z), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bcd", 32'(bcd), 0);
    chk("arst_valid", 32'(bcd_valid), 0);
    model_reset();
    #1;
    rst = 1'b0;

    // randomized traffic; Z commands biased toward hold so conversions finish
    repeat (400) begin
      r = $urandom_range(0, 31);
      if (r < 2)       rtz = 2'd1;
      else if (r == 2) rtz = 2'd3;
      else if (r == 3) rtz = 2'd2;
      else             rtz = 2'd0;
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rtz,
           1'($urandom_range(0, 1)), $urandom_range(0, MASK));
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    chk("drain", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
